// File: rtl/rst_ctrl_pkg.sv
// Shared types and constants for the system reset controller.
package rst_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_HOLDOFF = 2'b10
    } rst_state_e;

    localparam logic [1:0] CAUSE_POR = 2'b01;
    localparam logic [1:0] CAUSE_EXT = 2'b10;
    localparam logic [1:0] CAUSE_SW  = 2'b11;

    // A button edge wins over a simultaneous software request.
    function automatic logic [1:0] accept_cause(input logic btn_edge);
        logic [1:0] cause;
        if (btn_edge) begin
            cause = CAUSE_EXT;
        end else begin
            cause = CAUSE_SW;
        end
        return cause;
    endfunction

endpackage

// File: rtl/rst_ctrl_debounce.sv
// Push-button synchronizer and debouncer; outputs reflect the level being
// committed this cycle so the controller reacts on the same edge.
module rst_debounce
    import rst_ctrl_pkg::*;
#(
    parameter int NUM_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic EXT_RST_N,
    output logic BTN_PRESSED,
    output logic BTN_PRESS_EDGE
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] STABLE_ONE = DW'(1);

    logic [NUM_STAGES-1:0] sync_q;
    logic [NUM_STAGES-1:0] sync_d;
    logic                  level_q;
    logic                  level_d;
    logic [DW-1:0]         stable_q;
    logic [DW-1:0]         stable_d;
    logic                  synced_s;
    logic                  commit_s;

    // Next-state for the synchronizer chain and the stable-sample counter.
    always_comb begin
        sync_d         = {sync_q[NUM_STAGES-2:0], EXT_RST_N};
        synced_s       = sync_q[NUM_STAGES-1];
        level_d        = level_q;
        stable_d       = stable_q;
        commit_s       = 1'b0;
        if (synced_s == level_q) begin
            stable_d = '0;
        end else if (stable_q == DB_LAST) begin
            commit_s = 1'b1;
            level_d  = synced_s;
            stable_d = '0;
        end else begin
            stable_d = stable_q + STABLE_ONE;
        end
        BTN_PRESSED    = ~level_d;
        BTN_PRESS_EDGE = commit_s & ~synced_s;
    end

    // State registers; reset leaves the button in the released state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q   <= {NUM_STAGES{1'b1}};
            level_q  <= 1'b1;
            stable_q <= '0;
        end else begin
            sync_q   <= sync_d;
            level_q  <= level_d;
            stable_q <= stable_d;
        end
    end

endmodule

// File: rtl/rst_ctrl.sv
// System reset originator: merges power-on, push-button and software
// requests into one registered, minimum-width active-low reset.
module rst_ctrl
    import rst_ctrl_pkg::*;
#(
    parameter int NUM_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 8,
    parameter int MIN_PULSE       = 4,
    parameter int POR_CYCLES      = 16,
    parameter int HOLDOFF_CYCLES  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EXT_RST_N,
    input  logic                 SW_RST_REQ,
    input  logic [CNT_WIDTH-1:0] PULSE_LEN,
    output logic                 RST_OUT_N,
    output logic                 RST_BUSY,
    output logic                 RST_DONE,
    output logic [1:0]           RST_CAUSE
);

    localparam logic [CNT_WIDTH-1:0] MIN_LEN   = CNT_WIDTH'(MIN_PULSE);
    localparam logic [CNT_WIDTH-1:0] POR_LOAD  = CNT_WIDTH'(POR_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = CNT_WIDTH'(0);

    rst_state_e           state_q;
    rst_state_e           state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 rst_out_n_q;
    logic                 rst_out_n_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 done_q;
    logic                 done_d;
    logic [1:0]           cause_q;
    logic [1:0]           cause_d;
    logic                 btn_pressed_s;
    logic                 btn_edge_s;
    logic [CNT_WIDTH-1:0] pulse_load_s;

    rst_debounce #(
        .NUM_STAGES      (NUM_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK            (CLK),
        .RST            (RST),
        .EXT_RST_N      (EXT_RST_N),
        .BTN_PRESSED    (btn_pressed_s),
        .BTN_PRESS_EDGE (btn_edge_s)
    );

    // Requested width clamped to the minimum, converted to a count-down load.
    always_comb begin
        if (PULSE_LEN < MIN_LEN) begin
            pulse_load_s = MIN_LEN - CNT_ONE;
        end else begin
            pulse_load_s = PULSE_LEN - CNT_ONE;
        end
    end

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rst_out_n_d = rst_out_n_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cause_d     = cause_q;
        case (state_q)
            ST_IDLE: begin
                rst_out_n_d = 1'b1;
                busy_d      = 1'b0;
                if (btn_edge_s || SW_RST_REQ) begin
                    state_d     = ST_ASSERT;
                    rst_out_n_d = 1'b0;
                    busy_d      = 1'b1;
                    cnt_d       = pulse_load_s;
                    cause_d     = accept_cause(btn_edge_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                rst_out_n_d = 1'b0;
                busy_d      = 1'b1;
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (btn_pressed_s) begin
                    cnt_d = CNT_ZERO;
                end else begin
                    state_d     = ST_HOLDOFF;
                    rst_out_n_d = 1'b1;
                    cnt_d       = HOLD_LOAD;
                end
            end
            ST_HOLDOFF: begin
                rst_out_n_d = 1'b1;
                busy_d      = 1'b1;
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_ASSERT;
                rst_out_n_d = 1'b0;
                busy_d      = 1'b1;
                cnt_d       = POR_LOAD;
                cause_d     = CAUSE_POR;
            end
        endcase
    end

    // State, counter and output registers; RST restarts the power-on sequence.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= POR_LOAD;
            rst_out_n_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            cause_q     <= CAUSE_POR;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_out_n_q <= rst_out_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cause_q     <= cause_d;
        end
    end

    assign RST_OUT_N = rst_out_n_q;
    assign RST_BUSY  = busy_q;
    assign RST_DONE  = done_q;
    assign RST_CAUSE = cause_q;

endmodule

// File: tb/tb_rst_ctrl.sv
// Directed testbench for rst_ctrl: cycle-indexed pulse tracking after each stimulus.
module tb_rst_ctrl;

    logic       CLK;
    logic       RST;
    logic       EXT_RST_N;
    logic       SW_RST_REQ;
    logic [7:0] PULSE_LEN;
    logic       RST_OUT_N;
    logic       RST_BUSY;
    logic       RST_DONE;
    logic [1:0] RST_CAUSE;

    int total;
    int passed;
    // Tracker: samples taken #1 after each posedge since the last clear.
    int cyc, low_cnt, falls, fall_cyc, rise_cyc, dones, done_cyc, busy_cnt;
    logic prev_out;

    rst_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .EXT_RST_N  (EXT_RST_N),
        .SW_RST_REQ (SW_RST_REQ),
        .PULSE_LEN  (PULSE_LEN),
        .RST_OUT_N  (RST_OUT_N),
        .RST_BUSY   (RST_BUSY),
        .RST_DONE   (RST_DONE),
        .RST_CAUSE  (RST_CAUSE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_trk();
        cyc = 0; low_cnt = 0; falls = 0; fall_cyc = -1; rise_cyc = -1;
        dones = 0; done_cyc = -1; busy_cnt = 0;
        prev_out = RST_OUT_N;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (RST_OUT_N === 1'b0) low_cnt++;
        if (prev_out === 1'b1 && RST_OUT_N === 1'b0) begin
            falls++;
            fall_cyc = cyc;
        end
        if (prev_out === 1'b0 && RST_OUT_N === 1'b1) rise_cyc = cyc;
        if (RST_DONE === 1'b1) begin
            dones++;
            done_cyc = cyc;
        end
        if (RST_BUSY === 1'b1) busy_cnt++;
        prev_out = RST_OUT_N;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        total = 0; passed = 0;
        RST = 1'b0; EXT_RST_N = 1'b1; SW_RST_REQ = 1'b0; PULSE_LEN = 8'd10;
        #1;
        clear_trk();

        // Power-on: held 3 cycles, then released just after an edge.
        ticks(3);
        chk("por_hold_out", RST_OUT_N, 0);
        chk("por_hold_busy", RST_BUSY, 1);
        chk("por_hold_done", RST_DONE, 0);
        chk("por_hold_cause", RST_CAUSE, 1);
        RST = 1'b1;
        clear_trk();
        ticks(30);
        chk("por_rise_cyc", rise_cyc, 16);
        chk("por_busy_cycles", busy_cnt, 23);
        chk("por_done_cyc", done_cyc, 24);
        chk("por_done_count", dones, 1);
        chk("por_cause", RST_CAUSE, 1);
        chk("idle_out", RST_OUT_N, 1);
        chk("idle_busy", RST_BUSY, 0);

        // Software reset, length 10, with a dropped request during holdoff.
        PULSE_LEN = 8'd10;
        SW_RST_REQ = 1'b1;
        clear_trk();
        tick();
        SW_RST_REQ = 1'b0;
        ticks(11);
        SW_RST_REQ = 1'b1;
        tick();
        SW_RST_REQ = 1'b0;
        ticks(27);
        chk("sw_fall_cyc", fall_cyc, 1);
        chk("sw_low_cycles", low_cnt, 10);
        chk("sw_rise_cyc", rise_cyc, 11);
        chk("sw_done_cyc", done_cyc, 19);
        chk("sw_single_reset", falls, 1);
        chk("sw_done_count", dones, 1);
        chk("sw_cause", RST_CAUSE, 3);

        // Clamp: 2 and 0 both give the minimum width of 4.
        PULSE_LEN = 8'd2;
        SW_RST_REQ = 1'b1;
        clear_trk();
        tick();
        SW_RST_REQ = 1'b0;
        ticks(29);
        chk("clamp2_low_cycles", low_cnt, 4);
        chk("clamp2_done_cyc", done_cyc, 13);
        PULSE_LEN = 8'd0;
        SW_RST_REQ = 1'b1;
        clear_trk();
        tick();
        SW_RST_REQ = 1'b0;
        ticks(29);
        chk("clamp0_low_cycles", low_cnt, 4);
        chk("clamp0_falls", falls, 1);

        // Bounce for 40 cycles, then held low 60 cycles, then released.
        clear_trk();
        for (int i = 0; i < 8; i++) begin
            EXT_RST_N = (i % 2 == 1) ? 1'b1 : 1'b0;
            ticks(5);
        end
        chk("bounce_no_reset", falls, 0);
        EXT_RST_N = 1'b0;
        ticks(60);
        EXT_RST_N = 1'b1;
        ticks(40);
        chk("btn_falls", falls, 1);
        chk("btn_fall_cyc", fall_cyc, 58);
        chk("btn_rise_cyc", rise_cyc, 118);
        chk("btn_low_cycles", low_cnt, 60);
        chk("btn_done_cyc", done_cyc, 126);
        chk("btn_cause", RST_CAUSE, 2);

        // Software request coincident with the debounced press edge.
        PULSE_LEN = 8'd30;
        clear_trk();
        EXT_RST_N = 1'b0;
        ticks(17);
        SW_RST_REQ = 1'b1;
        tick();
        SW_RST_REQ = 1'b0;
        EXT_RST_N = 1'b1;
        ticks(52);
        chk("sim_falls", falls, 1);
        chk("sim_fall_cyc", fall_cyc, 18);
        chk("sim_low_cycles", low_cnt, 30);
        chk("sim_done_count", dones, 1);
        chk("sim_cause", RST_CAUSE, 2);

        // RST asserted at cycle 3 of a 10-cycle software reset.
        PULSE_LEN = 8'd10;
        SW_RST_REQ = 1'b1;
        clear_trk();
        tick();
        SW_RST_REQ = 1'b0;
        chk("mid_sw_cause", RST_CAUSE, 3);
        ticks(2);
        RST = 1'b0;
        #1;
        chk("mid_rst_out", RST_OUT_N, 0);
        chk("mid_rst_cause", RST_CAUSE, 1);
        chk("mid_rst_busy", RST_BUSY, 1);
        ticks(2);
        RST = 1'b1;
        clear_trk();
        ticks(30);
        chk("mid_por_rise_cyc", rise_cyc, 16);
        chk("mid_por_done_cyc", done_cyc, 24);
        chk("mid_por_done_count", dones, 1);
        chk("mid_por_cause", RST_CAUSE, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
